synapse_sched: RTL and testbench

SYNAPSE_SCHED -- requirements
Module: synapse_sched

---
 rtl/syn_pkg.sv | 15 +
 rtl/synapse_sched_synapse.sv | 28 ++
 rtl/synapse_sched.sv | 132 +++++++++++++
 tb/tb_synapse_sched.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/syn_pkg.sv
// Shared types and default sizing for the synapse scheduler.
// Optional feature macro: SYN_SCHED_SAT_EN (saturating accumulate).
package syn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N_IN   = 4;

endpackage

// File: rtl/synapse_sched_synapse.sv
// Single shared synapse: registered multiply, one cycle from operands to product.
// The product keeps only the low DATA_W bits of data*weight.
module synapse_sched_synapse
  import syn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_weight,
  output logic [DATA_W-1:0] o_prod
);

  logic [DATA_W-1:0] r_prod;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_prod <= '0;
    end else if (i_en) begin
      r_prod <= i_data * i_weight;
    end
  end

  assign o_prod = r_prod;

endmodule

// File: rtl/synapse_sched.sv
// Time-multiplexes N_IN data/weight pairs through one synapse and accumulates the sum.
// Define SYN_SCHED_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module synapse_sched
  import syn_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [N_IN*DATA_W-1:0]   data_i,
  input  logic [N_IN*DATA_W-1:0]   weight_i,
  input  logic                     ready_i,
  output logic                     busy_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        sum_o,
  output logic                     ovf_o
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

  state_t                   r_state;
  logic [N_IN*DATA_W-1:0]   r_data;
  logic [N_IN*DATA_W-1:0]   r_weight;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_inflight;
  logic [DATA_W-1:0]        r_acc;
  logic                     r_ovf;
  logic                     r_busy;
  logic                     r_valid;

  logic [DATA_W-1:0]        w_data;
  logic [DATA_W-1:0]        w_weight;
  logic [DATA_W-1:0]        w_prod;
  logic                     w_issue;
  logic [DATA_W:0]          w_sum;
  logic [DATA_W-1:0]        w_acc_next;

  // Select the latched pair addressed by the issue index.
  always_comb begin
    w_data   = '0;
    w_weight = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_data   = r_data[k*DATA_W +: DATA_W];
        w_weight = r_weight[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_issue = (r_state == ISSUE);
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_prod};

`ifdef SYN_SCHED_SAT_EN
  assign w_acc_next = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
`else
  assign w_acc_next = w_sum[DATA_W-1:0];
`endif

  synapse_sched_synapse #(
    .DATA_W (DATA_W)
  ) u_synapse (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_en     (w_issue),
    .i_data   (w_data),
    .i_weight (w_weight),
    .o_prod   (w_prod)
  );

  // The in-flight flag trails each issue by one cycle, so only real products are summed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_data     <= '0;
      r_weight   <= '0;
      r_idx      <= '0;
      r_inflight <= 1'b0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      if (r_inflight) begin
        r_acc <= w_acc_next;
        r_ovf <= r_ovf | w_sum[DATA_W];
      end
      r_inflight <= w_issue;

      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_data   <= data_i;
            r_weight <= weight_i;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_idx == LAST_IDX) begin
            r_state <= DRAIN;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o  = r_busy;
  assign valid_o = r_valid;
  assign sum_o   = r_acc;
  assign ovf_o   = r_ovf;

endmodule

// File: tb/tb_synapse_sched.sv
// Directed self-checking bench for synapse_sched (N_IN=4, DATA_W=8).
// Expected sums are hand-computed; the saturation case follows SYN_SCHED_SAT_EN.
module tb_synapse_sched;

  logic        clk_i;
  logic        rst_ni;
  logic        start_i;
  logic [31:0] data_i;
  logic [31:0] weight_i;
  logic        ready_i;
  logic        busy_o;
  logic        valid_o;
  logic [7:0]  sum_o;
  logic        ovf_o;

  int testCount = 0;
  int failCount = 0;

  synapse_sched #(
    .N_IN   (4),
    .DATA_W (8)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_i),
    .data_i   (data_i),
    .weight_i (weight_i),
    .ready_i  (ready_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .sum_o    (sum_o),
    .ovf_o    (ovf_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic stepCycle();
    @(posedge clk_i);
    #1;
  endtask

  // Cycle 0 is the start cycle; leaves the bench sitting in cycle 6 (DONE).
  task automatic applyStimulus(input logic [31:0] data, input logic [31:0] weight);
    data_i   = data;
    weight_i = weight;
    start_i  = 1'b1;
    stepCycle();
    start_i  = 1'b0;
    data_i   = 32'hFFFF_FFFF;
    weight_i = 32'hFFFF_FFFF;
    checkOutput("busyInIssue", 32'(busy_o), 32'd1);
    repeat (4) stepCycle();
    checkOutput("validLowCycle5", 32'(valid_o), 32'd0);
    stepCycle();
    checkOutput("validHighCycle6", 32'(valid_o), 32'd1);
  endtask

  task automatic acceptResult();
    ready_i = 1'b1;
    stepCycle();
    ready_i = 1'b0;
    checkOutput("validAfterAccept", 32'(valid_o), 32'd0);
    checkOutput("busyAfterAccept", 32'(busy_o), 32'd0);
  endtask

  initial begin
    rst_ni   = 1'b0;
    start_i  = 1'b0;
    ready_i  = 1'b0;
    data_i   = '0;
    weight_i = '0;
    repeat (2) stepCycle();

    checkOutput("rstBusy", 32'(busy_o), 32'd0);
    checkOutput("rstValid", 32'(valid_o), 32'd0);
    checkOutput("rstSum", 32'(sum_o), 32'd0);
    checkOutput("rstOvf", 32'(ovf_o), 32'd0);
    rst_ni = 1'b1;
    stepCycle();
    checkOutput("idleBusy", 32'(busy_o), 32'd0);

    // 1+2+3+4
    applyStimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd1, 8'd1, 8'd1, 8'd1});
    checkOutput("basicSum", 32'(sum_o), 32'd10);
    checkOutput("basicOvf", 32'(ovf_o), 32'd0);
    acceptResult();
    checkOutput("idleHoldsSum", 32'(sum_o), 32'd10);

    // 16*17=272 truncates to 16 inside the synapse; not an accumulator overflow
    applyStimulus({8'd0, 8'd0, 8'd0, 8'd16}, {8'd5, 8'd5, 8'd5, 8'd17});
    checkOutput("truncSum", 32'(sum_o), 32'd16);
    checkOutput("truncOvf", 32'(ovf_o), 32'd0);
    acceptResult();

    // 200 per pair: 800 wraps to 32, or clamps at 255
    applyStimulus({8'd100, 8'd100, 8'd100, 8'd100}, {8'd2, 8'd2, 8'd2, 8'd2});
`ifdef SYN_SCHED_SAT_EN
    checkOutput("ovfSum", 32'(sum_o), 32'd255);
`else
    checkOutput("ovfSum", 32'(sum_o), 32'd32);
`endif
    checkOutput("ovfFlag", 32'(ovf_o), 32'd1);
    acceptResult();
    checkOutput("idleHoldsOvf", 32'(ovf_o), 32'd1);

    // Exactly 255 is the largest sum without overflow
    applyStimulus({8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd1});
    checkOutput("edgeSum255", 32'(sum_o), 32'd255);
    checkOutput("edgeOvfClear", 32'(ovf_o), 32'd0);
    acceptResult();

    // 255+1=256 is the smallest overflowing sum
    applyStimulus({8'd0, 8'd0, 8'd1, 8'd255}, {8'd0, 8'd0, 8'd1, 8'd1});
`ifdef SYN_SCHED_SAT_EN
    checkOutput("edgeSum256", 32'(sum_o), 32'd255);
`else
    checkOutput("edgeSum256", 32'(sum_o), 32'd0);
`endif
    checkOutput("edgeOvf256", 32'(ovf_o), 32'd1);
    acceptResult();

    // Back-pressure in DONE with start_i pulsing: result holds, nothing queued
    applyStimulus({8'd4, 8'd3, 8'd2, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2});
    for (int i = 0; i < 5; i++) begin
      start_i = (i % 2 == 0);
      stepCycle();
      checkOutput("stallValid", 32'(valid_o), 32'd1);
      checkOutput("stallSum", 32'(sum_o), 32'd20);
      checkOutput("stallBusy", 32'(busy_o), 32'd1);
    end
    start_i = 1'b1;
    acceptResult();
    start_i = 1'b0;
    stepCycle();
    checkOutput("noQueuedStart", 32'(busy_o), 32'd0);
    checkOutput("stallSumHeld", 32'(sum_o), 32'd20);

    // Reset in cycle 3 aborts the pass; a start right after release runs normally
    data_i   = {8'd9, 8'd9, 8'd9, 8'd9};
    weight_i = {8'd9, 8'd9, 8'd9, 8'd9};
    start_i  = 1'b1;
    stepCycle();
    start_i  = 1'b0;
    repeat (2) stepCycle();
    rst_ni = 1'b0;
    stepCycle();
    checkOutput("abortBusy", 32'(busy_o), 32'd0);
    checkOutput("abortValid", 32'(valid_o), 32'd0);
    checkOutput("abortSum", 32'(sum_o), 32'd0);
    checkOutput("abortOvf", 32'(ovf_o), 32'd0);
    rst_ni = 1'b1;
    // 5*3 + 5 + 5 + 5
    applyStimulus({8'd5, 8'd5, 8'd5, 8'd5}, {8'd1, 8'd1, 8'd1, 8'd3});
    checkOutput("postResetSum", 32'(sum_o), 32'd30);
    checkOutput("postResetOvf", 32'(ovf_o), 32'd0);
    acceptResult();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
